// File: rtl/neuron_sequencer_pkg.sv
// Shared definitions for the neuron sequencer core: the state encoding,
// default core sizes and the index widths derived from them.
package neuron_sequencer_pkg;

  // Index width for n entries; a single-entry index still needs one bit.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int DEF_NUM_NEURONS = 256;
  localparam int DEF_NUM_AXONS   = 256;
  localparam int DEF_NUM_WEIGHTS = 4;

  localparam int NEURON_W = idx_w(DEF_NUM_NEURONS);
  localparam int AXON_W   = idx_w(DEF_NUM_AXONS);
  localparam int WEIGHT_W = idx_w(DEF_NUM_WEIGHTS);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    READ  = 3'd1,
    LOAD  = 3'd2,
    INTEG = 3'd3,
    WRITE = 3'd4,
    SPIKE = 3'd5,
    DONE  = 3'd6
  } seq_state_e;

endpackage

// File: rtl/neuron_sequencer_axon_scan_counter.sv
// Axon index counter for the integration scan; wraps to zero after the
// last axon and flags the terminal count.
module axon_scan_counter #(
  parameter int NUM_AXONS = 4,
  parameter int AW        = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clear,
  input  logic          en,
  output logic [AW-1:0] a,
  output logic          last
);

  logic [AW-1:0] a_q, a_d;

  assign last = (a_q == AW'(NUM_AXONS - 1));
  assign a    = a_q;

  always_comb begin
    a_d = a_q;
    if (clear) begin
      a_d = '0;
    end else if (en) begin
      a_d = last ? '0 : a_q + AW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) a_q <= '0;
    else      a_q <= a_d;
  end

endmodule

// File: rtl/neuron_sequencer.sv
// Time-step sequencer: walks every neuron of the core once per tick, driving
// the neuron datapath through load, axon integration, write-back and spike-out.
module neuron_sequencer
  import neuron_sequencer_pkg::*;
#(
  parameter int NUM_NEURONS = DEF_NUM_NEURONS,
  parameter int NUM_AXONS   = DEF_NUM_AXONS,
  parameter int NUM_WEIGHTS = DEF_NUM_WEIGHTS
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          tick,
  input  logic [NUM_AXONS-1:0]          axon_spikes,
  input  logic [NUM_AXONS*idx_w(NUM_WEIGHTS)-1:0] axon_types,
  output logic [idx_w(NUM_NEURONS)-1:0] csram_addr,
  input  logic [NUM_AXONS-1:0]          synapses,
  output logic                          csram_we,
  output logic [idx_w(NUM_WEIGHTS)-1:0] neuron_instruction,
  output logic                          integrator_reg_en,
  output logic                          write_current_potential,
  output logic                          next_neuron,
  input  logic                          spike_in,
  output logic                          spike_valid,
  input  logic                          spike_ready,
  output logic [idx_w(NUM_NEURONS)-1:0] spike_neuron,
  output logic                          busy,
  output logic                          done,
  output logic                          tick_overrun
);

  localparam int NW = idx_w(NUM_NEURONS);
  localparam int AW = idx_w(NUM_AXONS);
  localparam int TW = idx_w(NUM_WEIGHTS);

  seq_state_e           state_q, state_d;
  logic [NW-1:0]        n_q, n_d;
  logic [NUM_AXONS-1:0] snap_q, snap_d;
  logic [NUM_AXONS-1:0] syn_q, syn_d;
  logic                 overrun_q, overrun_d;

  logic          scan_clear, scan_en, scan_last;
  logic [AW-1:0] a_idx;

  axon_scan_counter #(
    .NUM_AXONS(NUM_AXONS),
    .AW       (AW)
  ) u_scan (
    .clk  (clk),
    .rst  (rst),
    .clear(scan_clear),
    .en   (scan_en),
    .a    (a_idx),
    .last (scan_last)
  );

  assign busy         = (state_q != IDLE);
  assign tick_overrun = overrun_q;

  always_comb begin
    state_d                 = state_q;
    n_d                     = n_q;
    snap_d                  = snap_q;
    syn_d                   = syn_q;
    overrun_d               = tick && (state_q != IDLE);
    scan_clear              = 1'b0;
    scan_en                 = 1'b0;
    csram_addr              = '0;
    csram_we                = 1'b0;
    neuron_instruction      = '0;
    integrator_reg_en       = 1'b0;
    write_current_potential = 1'b0;
    next_neuron             = 1'b0;
    spike_valid             = 1'b0;
    spike_neuron            = '0;
    done                    = 1'b0;

    case (state_q)
      IDLE: begin
        if (tick) begin
          snap_d  = axon_spikes;
          n_d     = '0;
          state_d = READ;
        end
      end
      READ: begin
        csram_addr = n_q;
        state_d    = LOAD;
      end
      LOAD: begin
        next_neuron             = 1'b1;
        write_current_potential = 1'b1;
        integrator_reg_en       = 1'b1;
        syn_d                   = synapses;
        scan_clear              = 1'b1;
        state_d                 = INTEG;
      end
      INTEG: begin
        scan_en            = 1'b1;
        neuron_instruction = axon_types[int'(a_idx)*TW +: TW];
        integrator_reg_en  = syn_q[a_idx] & snap_q[a_idx];
        if (scan_last) state_d = WRITE;
      end
      WRITE: begin
        csram_we   = 1'b1;
        csram_addr = n_q;
        if (spike_in) begin
          state_d = SPIKE;
        end else if (n_q == NW'(NUM_NEURONS - 1)) begin
          state_d = DONE;
        end else begin
          n_d     = n_q + NW'(1);
          state_d = READ;
        end
      end
      SPIKE: begin
        // Held stable until the consumer accepts; advance on the handshake cycle.
        spike_valid  = 1'b1;
        spike_neuron = n_q;
        if (spike_ready) begin
          if (n_q == NW'(NUM_NEURONS - 1)) begin
            state_d = DONE;
          end else begin
            n_d     = n_q + NW'(1);
            state_d = READ;
          end
        end
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      n_q       <= '0;
      snap_q    <= '0;
      syn_q     <= '0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      n_q       <= n_d;
      snap_q    <= snap_d;
      syn_q     <= syn_d;
      overrun_q <= overrun_d;
    end
  end

endmodule

// File: doc/neuron_sequencer.md
NEURON_SEQUENCER -- requirements
Module: neuron_sequencer

Interface
REQ-001 SHALL have parameter NUM_NEURONS, default 256, neurons per core.
REQ-002 SHALL have parameter NUM_AXONS, default 256, axons per core.
REQ-003 SHALL have parameter NUM_WEIGHTS, default 4, axon types (weight count).
REQ-004 SHALL have port clk  input  1  single clock; all logic rising-edge.
REQ-005 SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port tick  input  1  start of one time-step pass.
REQ-007 SHALL have port axon_spikes  input  NUM_AXONS  incoming axon spike vector.
REQ-008 SHALL have port axon_types  input  NUM_AXONS*clog2(NUM_WEIGHTS)  per-axon type; axon a occupies slice a.
REQ-009 SHALL have port csram_addr  output  clog2(NUM_NEURONS)  neuron parameter memory address.
REQ-010 SHALL have port synapses  input  NUM_AXONS  connectivity row of addressed neuron, valid one cycle after address.
REQ-011 SHALL have port csram_we  output  1  potential write-back strobe.
REQ-012 SHALL have ports neuron_instruction (clog2(NUM_WEIGHTS)), integrator_reg_en, write_current_potential and next_neuron, each an output (1 bit unless stated) driving the neuron datapath.
REQ-013 SHALL have port spike_in  input  1  threshold-unit spike for the current neuron.
REQ-014 SHALL have ports spike_valid (output, 1), spike_ready (input, 1) and spike_neuron (output, clog2(NUM_NEURONS)) forming the downstream spike handshake.
REQ-015 SHALL have ports busy, done and tick_overrun, each an output of width 1.

Function
REQ-016 SHALL implement states IDLE, READ, LOAD, INTEG, WRITE, SPIKE, DONE.
REQ-017 SHALL, in IDLE with tick=1, latch axon_spikes into an internal snapshot, clear neuron index n to 0 and go to READ.
REQ-018 SHALL, in READ, drive csram_addr=n for exactly one cycle and then go to LOAD.
REQ-019 SHALL, in LOAD, assert next_neuron, write_current_potential and integrator_reg_en for one cycle and register synapses.
REQ-020 SHALL, in INTEG, scan axon index a from 0 to NUM_AXONS-1, one per cycle.
REQ-021 SHALL, in each INTEG cycle, set neuron_instruction=axon_types[a] and integrator_reg_en=synapse[a] AND snapshot[a].
REQ-022 SHALL, in WRITE, assert csram_we for one cycle at csram_addr=n and sample spike_in.
REQ-023 SHALL, when the sampled spike_in=1, enter SPIKE and hold spike_valid=1 with spike_neuron=n stable until spike_ready=1; the transfer completes in the cycle both are high.
REQ-024 SHALL, after WRITE with no spike or after SPIKE completes, go to DONE if n=NUM_NEURONS-1, else increment n and go to READ.
REQ-025 SHALL take exactly NUM_AXONS+3 cycles per neuron, excluding SPIKE stall.
REQ-026 SHALL pulse done for the single DONE cycle and then return to IDLE.
REQ-027 SHALL hold busy high in every state except IDLE.
REQ-028 SHALL ignore tick while busy and then pulse tick_overrun for one cycle; the running pass is unaffected.
REQ-029 SHALL ignore changes to axon_spikes after the snapshot for the rest of the pass.
REQ-030 SHALL keep all datapath strobes low outside the states named above, and neuron_instruction=0 outside INTEG.

Reset
REQ-031 SHALL, on rst=0, immediately force state IDLE, n=0, a=0, snapshot=0, and every output to 0, including mid-pass.
REQ-032 SHALL, after rst deasserts, begin no pass until a fresh tick.

Structure
REQ-033 SHALL place the state encoding and the derived widths clog2(NUM_NEURONS), clog2(NUM_AXONS) and clog2(NUM_WEIGHTS) in the shared core package.
REQ-034 SHALL contain one sub-module, axon_scan_counter, holding index a with a terminal-count flag.

Verification (NUM_NEURONS=4, NUM_AXONS=4, NUM_WEIGHTS=4)
REQ-035 SHALL verify reset: pull rst low during INTEG -> all outputs become 0 without a clock edge, and busy=0.
REQ-036 SHALL verify empty pass: tick with all synapses=0 -> csram_we pulses 4 times, 7 cycles apart; integrator_reg_en is high only in LOAD cycles; done pulses one cycle wide 29 cycles after tick is sampled.
REQ-037 SHALL verify integration: synapses=4'b0101, axon_spikes=4'b0111, types a0..a3 = 0,1,2,3 -> integrator_reg_en high in the a=0 and a=2 INTEG cycles, with neuron_instruction 0 and 2 respectively.
REQ-038 SHALL verify backpressure: spike_in=1 at neuron 2 WRITE with spike_ready low for 5 cycles -> spike_valid held 6 cycles, spike_neuron=2 stable, READ of neuron 3 follows the handshake cycle.
REQ-039 SHALL verify overrun and snapshot: tick again mid-pass and flip axon_spikes -> tick_overrun pulses once, integration pattern and done timing unchanged.
